// File: rtl/wb2ps_pkg.sv
// Shared constants and types for the Wishbone->PSRAM write burst front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: register byte offsets, CTL bit positions, pad mask, buffered
// word type and session FSM state type.
package wb2ps_pkg;

  localparam logic [11:0] REG_WADRS = 12'h030;
  localparam logic [11:0] REG_WAREA = 12'h034;
  localparam logic [11:0] REG_WDATA = 12'h038;
  localparam logic [11:0] REG_CTL   = 12'h03C;
  localparam logic [11:0] REG_LEVEL = 12'h040;
  localparam logic [11:0] REG_WOFS  = 12'h044;

  localparam int CTL_START = 0;
  localparam int CTL_END   = 1;
  localparam int CTL_RING  = 2;
  localparam int CTL_EFLAG = 8;
  localparam int CTL_ERR   = 9;
  localparam int CTL_RUN   = 16;
  localparam int CTL_FULL  = 17;

  // Pad words carry no valid bytes.
  localparam logic [3:0] MASK_PAD = 4'hF;

  // One buffered stream word: data plus byte mask (1 = byte not written).
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } bword_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAD, S_DRAIN} sess_state_t;

endpackage

// File: rtl/wb2ps_burst_buf.sv
// Burst buffer: circular word RAM plus burst-descriptor FIFO feeding the word stream.
// Latency: a word pushed in the cycle its burst is committed is visible on the stream next cycle.
// Backpressure: outputs hold while bst_valid & ~bst_ready; caller must not push when full.
//
// Ports: push_vld/push_dat write one word; commit_vld/commit_addr close the
// burst whose last word is pushed in the same cycle; level/full report word
// occupancy; drained flags that no committed burst remains after this cycle;
// bst_* is the outgoing word stream.
module wb2ps_burst_buf
  import wb2ps_pkg::*;
#(
  parameter int BURST_WORDS  = 16,
  parameter int DEPTH_BURSTS = 4,
  parameter int ADDR_W       = 23,
  localparam int CAP    = DEPTH_BURSTS * BURST_WORDS,
  localparam int PTR_W  = $clog2(CAP),
  localparam int CNT_W  = PTR_W + 1,
  localparam int DPTR_W = $clog2(DEPTH_BURSTS),
  localparam int WIDX_W = $clog2(BURST_WORDS)
) (
  input  logic              cpuclk,
  input  logic              WSHRST,
  input  logic              push_vld,
  input  bword_t            push_dat,
  input  logic              commit_vld,
  input  logic [ADDR_W-1:0] commit_addr,
  output logic [CNT_W-1:0]  level,
  output logic              full,
  output logic              drained,
  output logic              bst_valid,
  input  logic              bst_ready,
  output logic [ADDR_W-1:0] bst_addr,
  output logic [31:0]       bst_data,
  output logic [3:0]        bst_mask,
  output logic              bst_first,
  output logic              bst_last
);

  bword_t            mem      [CAP];
  logic [ADDR_W-1:0] desc_mem [DEPTH_BURSTS];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DPTR_W-1:0] desc_wr, desc_rd;
  logic [DPTR_W:0]   desc_cnt;
  logic              pop, pop_last;

  // Bursts occupy whole aligned RAM slots, so the low read-pointer bits are
  // the word index within the current burst.
  assign bst_valid = (desc_cnt != '0);
  assign pop       = bst_valid & bst_ready;
  assign bst_first = (rd_ptr[WIDX_W-1:0] == '0);
  assign bst_last  = &rd_ptr[WIDX_W-1:0];
  assign pop_last  = pop & bst_last;
  assign bst_data  = mem[rd_ptr].data;
  assign bst_mask  = mem[rd_ptr].mask;
  assign bst_addr  = desc_mem[desc_rd];
  assign full      = (level == CNT_W'(CAP));
  assign drained   = (desc_cnt == '0) | ((desc_cnt == (DPTR_W+1)'(1)) & pop_last);

  always_ff @(posedge cpuclk) begin
    if (push_vld)   mem[wr_ptr]       <= push_dat;
    if (commit_vld) desc_mem[desc_wr] <= commit_addr;
  end

  always_ff @(posedge cpuclk or posedge WSHRST) begin
    if (WSHRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      desc_wr  <= '0;
      desc_rd  <= '0;
      desc_cnt <= '0;
    end else begin
      if (push_vld)   wr_ptr  <= wr_ptr + 1'b1;
      if (pop)        rd_ptr  <= rd_ptr + 1'b1;
      if (commit_vld) desc_wr <= desc_wr + 1'b1;
      if (pop_last)   desc_rd <= desc_rd + 1'b1;
      level    <= level + CNT_W'(push_vld) - CNT_W'(pop);
      desc_cnt <= desc_cnt + (DPTR_W+1)'(commit_vld) - (DPTR_W+1)'(pop_last);
    end
  end

endmodule

// File: rtl/wb2ps_wburst_fifo.sv
// CPU register front-end packing WDATA writes into aligned PSRAM write bursts.
// Latency: reads take 2 cycles; writes accept in 1; a burst streams the cycle after its last word.
// Backpressure: WDATA write stalls (ready=0) when buffer full or padding; stream holds on ~bst_ready.
//
// Ports: reg_mem_* is the CPU register bus (wstrb==0 means read); bst_* is
// the committed-burst word stream; run is high during a session and done_p
// pulses once when the session's last burst has left.
module wb2ps_wburst_fifo
  import wb2ps_pkg::*;
#(
  parameter int BURST_WORDS  = 16,
  parameter int DEPTH_BURSTS = 4,
  parameter int ADDR_W       = 23
) (
  input  logic              cpuclk,
  input  logic              WSHRST,
  input  logic [11:0]       reg_mem_addr,
  input  logic [31:0]       reg_mem_wdata,
  output logic [31:0]       reg_mem_rdata,
  input  logic [3:0]        reg_mem_wstrb,
  input  logic              reg_mem_valid,
  output logic              reg_mem_ready,
  output logic              bst_valid,
  input  logic              bst_ready,
  output logic [ADDR_W-1:0] bst_addr,
  output logic [31:0]       bst_data,
  output logic [3:0]        bst_mask,
  output logic              bst_first,
  output logic              bst_last,
  output logic              run,
  output logic              done_p
);

  localparam int CAP    = DEPTH_BURSTS * BURST_WORDS;
  localparam int CNT_W  = $clog2(CAP) + 1;
  localparam int WIDX_W = $clog2(BURST_WORDS);
  localparam int BB_W   = $clog2(BURST_WORDS * 4);

  sess_state_t       state, state_nxt;
  logic [ADDR_W-1:0] wadrs, warea, base, bst_ofs;
  logic [ADDR_W:0]   area, offset, ofs_nxt;
  logic [WIDX_W-1:0] pcnt;
  logic              ring, eflag, err, rstate;
  logic [CNT_W-1:0]  level;
  logic              full, drained;
  logic              wr, rd, wdata_wr, ctl_wr, start_req, end_req;
  logic              push_real, push_pad, push_vld, burst_done, ofs_hit, partial_after;
  bword_t            push_dat;
  logic [31:0]       rd_val;

  assign run       = (state != S_IDLE);
  assign wr        = reg_mem_valid & (reg_mem_wstrb != 4'h0);
  assign rd        = reg_mem_valid & (reg_mem_wstrb == 4'h0);
  assign wdata_wr  = wr & (reg_mem_addr == REG_WDATA);
  assign ctl_wr    = wr & (reg_mem_addr == REG_CTL);
  assign start_req = ctl_wr & reg_mem_wdata[CTL_START];
  assign end_req   = ctl_wr & reg_mem_wdata[CTL_END];

  assign push_real  = wdata_wr & (state == S_RUN) & ~full;
  assign push_pad   = (state == S_PAD) & ~full;
  assign push_vld   = push_real | push_pad;
  assign burst_done = push_vld & (pcnt == WIDX_W'(BURST_WORDS - 1));
  assign ofs_nxt    = offset + (ADDR_W+1)'(4);
  assign ofs_hit    = (ofs_nxt >= area);
  // Partial count after this cycle is non-zero: padding is required on end.
  assign partial_after = push_vld ? ~burst_done : (pcnt != '0);

  always_comb begin
    push_dat.data = reg_mem_wdata;
    push_dat.mask = ~reg_mem_wstrb;
    if (push_pad) begin
      push_dat.data = 32'h0;
      push_dat.mask = MASK_PAD;
    end
  end

  wb2ps_burst_buf #(
    .BURST_WORDS (BURST_WORDS),
    .DEPTH_BURSTS(DEPTH_BURSTS),
    .ADDR_W      (ADDR_W)
  ) u_buf (
    .cpuclk     (cpuclk),
    .WSHRST     (WSHRST),
    .push_vld   (push_vld),
    .push_dat   (push_dat),
    .commit_vld (burst_done),
    .commit_addr(base + bst_ofs),
    .level      (level),
    .full       (full),
    .drained    (drained),
    .bst_valid  (bst_valid),
    .bst_ready  (bst_ready),
    .bst_addr   (bst_addr),
    .bst_data   (bst_data),
    .bst_mask   (bst_mask),
    .bst_first  (bst_first),
    .bst_last   (bst_last)
  );

  // Session FSM
  always_ff @(posedge cpuclk or posedge WSHRST) begin
    if (WSHRST) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req) state_nxt = S_RUN;
      S_RUN:   if (end_req || (push_real && ofs_hit && !ring))
                 state_nxt = partial_after ? S_PAD : S_DRAIN;
      S_PAD:   if (burst_done) state_nxt = S_DRAIN;
      S_DRAIN: if (drained) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reg_mem_ready = 1'b0;
    if (rd)
      reg_mem_ready = rstate;
    else if (wr)
      reg_mem_ready = !(wdata_wr && ((state == S_PAD) || ((state == S_RUN) && full)));
  end

  always_comb begin
    rd_val = 32'h0;
    case (reg_mem_addr)
      REG_WADRS: rd_val = 32'(wadrs);
      REG_WAREA: rd_val = 32'(warea);
      REG_CTL: begin
        rd_val[CTL_RING]  = ring;
        rd_val[CTL_EFLAG] = eflag;
        rd_val[CTL_ERR]   = err;
        rd_val[CTL_RUN]   = run;
        rd_val[CTL_FULL]  = full;
      end
      REG_LEVEL: rd_val = 32'(level);
      REG_WOFS:  rd_val = 32'(offset);
      default:   rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge cpuclk or posedge WSHRST) begin
    if (WSHRST) begin
      reg_mem_rdata <= '0;
      rstate        <= 1'b0;
      wadrs         <= '0;
      warea         <= '0;
      base          <= '0;
      area          <= '0;
      offset        <= '0;
      bst_ofs       <= '0;
      pcnt          <= '0;
      ring          <= 1'b0;
      eflag         <= 1'b0;
      err           <= 1'b0;
      done_p        <= 1'b0;
    end else begin
      done_p <= 1'b0;
      // First read cycle captures the data, second one completes it.
      if (rd && !rstate) begin
        rstate        <= 1'b1;
        reg_mem_rdata <= rd_val;
      end else begin
        rstate <= 1'b0;
      end
      if (wr && reg_mem_addr == REG_WADRS) wadrs <= {reg_mem_wdata[ADDR_W-1:BB_W], BB_W'(0)};
      if (wr && reg_mem_addr == REG_WAREA) warea <= {reg_mem_wdata[ADDR_W-1:2], 2'b00};
      if (ctl_wr && reg_mem_wdata[CTL_EFLAG]) eflag <= 1'b0;
      if (ctl_wr && reg_mem_wdata[CTL_ERR])   err   <= 1'b0;
      if (start_req) begin
        if (state == S_IDLE) begin
          base   <= wadrs;
          // A zero length selects the whole address space.
          area   <= (warea == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, warea};
          ring   <= reg_mem_wdata[CTL_RING];
          offset <= '0;
          pcnt   <= '0;
          eflag  <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (wdata_wr && (state == S_IDLE || state == S_DRAIN)) err <= 1'b1;
      if (push_vld) begin
        pcnt <= pcnt + 1'b1;
        if (pcnt == '0) bst_ofs <= offset[ADDR_W-1:0];
      end
      if (push_real) offset <= (ofs_hit && ring) ? '0 : ofs_nxt;
      if (state == S_DRAIN && drained) begin
        eflag  <= 1'b1;
        done_p <= 1'b1;
      end
    end
  end

endmodule
